return_addr_stack: RTL and testbench

RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

---
 rtl/return_addr_stack.sv | 108 ++++++++++
 tb/tb_return_addr_stack.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return address stack for call/return target prediction
// Optional macro RAS_CHECKPOINT_EN: restore tos/count/top entry from a checkpoint on recovery.
module return_addr_stack #(
   parameter int SIZE_PC   = 32,
   parameter int DEPTH     = 16,
   parameter int DEPTH_LOG = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall_i,
   input  logic                 pushFlag_i,
   input  logic [SIZE_PC-1:0]   callPC_i,
   input  logic                 popFlag_i,
   input  logic                 recoverFlag_i,
`ifdef RAS_CHECKPOINT_EN
   input  logic [DEPTH_LOG-1:0] cpTos_i,
   input  logic [DEPTH_LOG:0]   cpCount_i,
   input  logic [SIZE_PC-1:0]   cpTopAddr_i,
`endif
   output logic [SIZE_PC-1:0]   addrRAS_CP_o,
   output logic [DEPTH_LOG-1:0] tos_o,
   output logic [DEPTH_LOG:0]   count_o,
   output logic                 rasEmpty_o,
   output logic                 rasFull_o
);

   localparam logic [DEPTH_LOG:0] COUNT_FULL = (DEPTH_LOG+1)'(DEPTH);

   logic [SIZE_PC-1:0]   entry [DEPTH];
   logic [DEPTH_LOG-1:0] tos;
   logic [DEPTH_LOG:0]   count;

   logic [DEPTH_LOG-1:0] tos_nxt;
   logic [DEPTH_LOG:0]   count_nxt;
   logic                 wr_en;
   logic [DEPTH_LOG-1:0] wr_idx;
   logic [SIZE_PC-1:0]   wr_data;
   logic [SIZE_PC-1:0]   ret_addr;
   logic                 full;
   logic                 empty;

   // Return target is the instruction after the call plus its delay slot.
   assign ret_addr = callPC_i + SIZE_PC'(8);
   assign full     = (count == COUNT_FULL);
   assign empty    = (count == '0);

   always_comb begin
      tos_nxt   = tos;
      count_nxt = count;
      wr_en     = 1'b0;
      wr_idx    = tos;
      wr_data   = ret_addr;
      if (recoverFlag_i) begin
`ifdef RAS_CHECKPOINT_EN
         tos_nxt   = cpTos_i;
         count_nxt = cpCount_i;
         wr_en     = 1'b1;
         wr_idx    = cpTos_i;
         wr_data   = cpTopAddr_i;
`else
         tos_nxt   = '0;
         count_nxt = '0;
`endif
      end else if (!stall_i) begin
         if (pushFlag_i && popFlag_i) begin
            wr_en = 1'b1;
         end else if (pushFlag_i) begin
            // When full the new entry lands on the oldest slot; count saturates.
            tos_nxt = tos + DEPTH_LOG'(1);
            wr_en   = 1'b1;
            wr_idx  = tos + DEPTH_LOG'(1);
            if (!full) begin
               count_nxt = count + (DEPTH_LOG+1)'(1);
            end
         end else if (popFlag_i && !empty) begin
            tos_nxt   = tos - DEPTH_LOG'(1);
            count_nxt = count - (DEPTH_LOG+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tos   <= '0;
         count <= '0;
      end else begin
         tos   <= tos_nxt;
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry[i] <= '0;
         end
      end else if (wr_en) begin
         entry[wr_idx] <= wr_data;
      end
   end

   assign addrRAS_CP_o = entry[tos];
   assign tos_o        = tos;
   assign count_o      = count;
   assign rasEmpty_o   = empty;
   assign rasFull_o    = full;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - randomized and directed bench for return_addr_stack (DEPTH=4)
module tb_return_addr_stack;

   localparam int SIZE_PC   = 32;
   localparam int DEPTH     = 4;
   localparam int DEPTH_LOG = 2;

   logic                 clk;
   logic                 reset;
   logic                 stall_i;
   logic                 pushFlag_i;
   logic [SIZE_PC-1:0]   callPC_i;
   logic                 popFlag_i;
   logic                 recoverFlag_i;
   logic [DEPTH_LOG-1:0] cpTos_i;
   logic [DEPTH_LOG:0]   cpCount_i;
   logic [SIZE_PC-1:0]   cpTopAddr_i;
   logic [SIZE_PC-1:0]   addrRAS_CP_o;
   logic [DEPTH_LOG-1:0] tos_o;
   logic [DEPTH_LOG:0]   count_o;
   logic                 rasEmpty_o;
   logic                 rasFull_o;

   int checks_total;
   int checks_passed;

   // Reference model: plain arrays and modular arithmetic.
   logic [31:0] m_ent [DEPTH];
   int          m_tos;
   int          m_count;

   return_addr_stack #(
      .SIZE_PC  (SIZE_PC),
      .DEPTH    (DEPTH),
      .DEPTH_LOG(DEPTH_LOG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_i      (stall_i),
      .pushFlag_i   (pushFlag_i),
      .callPC_i     (callPC_i),
      .popFlag_i    (popFlag_i),
      .recoverFlag_i(recoverFlag_i),
`ifdef RAS_CHECKPOINT_EN
      .cpTos_i      (cpTos_i),
      .cpCount_i    (cpCount_i),
      .cpTopAddr_i  (cpTopAddr_i),
`endif
      .addrRAS_CP_o (addrRAS_CP_o),
      .tos_o        (tos_o),
      .count_o      (count_o),
      .rasEmpty_o   (rasEmpty_o),
      .rasFull_o    (rasFull_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_ent[i] = 32'h0;
      m_tos   = 0;
      m_count = 0;
   endtask

   task automatic model_step();
      if (recoverFlag_i) begin
`ifdef RAS_CHECKPOINT_EN
         m_tos        = int'(cpTos_i);
         m_count      = int'(cpCount_i);
         m_ent[m_tos] = cpTopAddr_i;
`else
         m_tos   = 0;
         m_count = 0;
`endif
      end else if (!stall_i) begin
         if (pushFlag_i && popFlag_i) begin
            m_ent[m_tos] = callPC_i + 32'd8;
         end else if (pushFlag_i) begin
            m_tos        = (m_tos + 1) % DEPTH;
            m_ent[m_tos] = callPC_i + 32'd8;
            if (m_count < DEPTH) m_count = m_count + 1;
         end else if (popFlag_i && m_count > 0) begin
            m_tos   = (m_tos + DEPTH - 1) % DEPTH;
            m_count = m_count - 1;
         end
      end
   endtask

   // Called on a falling edge: drive inputs, clock once, update the model, return on the next falling edge.
   task automatic cycle(input logic push, input logic pop, input logic stall, input logic rec,
                        input logic [31:0] pc, input logic [1:0] ctos, input logic [2:0] ccnt,
                        input logic [31:0] ctop);
      pushFlag_i    = push;
      popFlag_i     = pop;
      stall_i       = stall;
      recoverFlag_i = rec;
      callPC_i      = pc;
      cpTos_i       = ctos;
      cpCount_i     = ccnt;
      cpTopAddr_i   = ctop;
      @(posedge clk);
      model_step();
      @(negedge clk);
      pushFlag_i    = 1'b0;
      popFlag_i     = 1'b0;
      stall_i       = 1'b0;
      recoverFlag_i = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks_total++;
      if (addrRAS_CP_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", addrRAS_CP_o); else checks_passed++;
      checks_total++;
      if (tos_o !== 2'd0) $display("FAIL reset_tos: got %0d want 0", tos_o); else checks_passed++;
      checks_total++;
      if (count_o !== 3'd0) $display("FAIL reset_count: got %0d want 0", count_o); else checks_passed++;
      checks_total++;
      if (rasEmpty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", rasEmpty_o); else checks_passed++;
      checks_total++;
      if (rasFull_o !== 1'b0) $display("FAIL reset_full: got %b want 0", rasFull_o); else checks_passed++;
   endtask

   task automatic test_single_push();
      do_reset();
      cycle(1, 0, 0, 0, 32'h1000, 0, 0, 0);
      checks_total++;
      if (addrRAS_CP_o !== 32'h1008) $display("FAIL push_addr: got %h want 1008", addrRAS_CP_o); else checks_passed++;
      checks_total++;
      if (tos_o !== 2'd1) $display("FAIL push_tos: got %0d want 1", tos_o); else checks_passed++;
      checks_total++;
      if (count_o !== 3'd1) $display("FAIL push_count: got %0d want 1", count_o); else checks_passed++;
      checks_total++;
      if (rasEmpty_o !== 1'b0) $display("FAIL push_empty: got %b want 0", rasEmpty_o); else checks_passed++;
   endtask

   task automatic test_wrap_full();
      logic [31:0] want [4];
      want[0] = 32'h408; want[1] = 32'h308; want[2] = 32'h208; want[3] = 32'h508;
      do_reset();
      for (int i = 1; i <= 5; i++) cycle(1, 0, 0, 0, 32'h100 * i, 0, 0, 0);
      checks_total++;
      if (count_o !== 3'd4) $display("FAIL full_count: got %0d want 4", count_o); else checks_passed++;
      checks_total++;
      if (rasFull_o !== 1'b1) $display("FAIL full_flag: got %b want 1", rasFull_o); else checks_passed++;
      checks_total++;
      if (addrRAS_CP_o !== 32'h508) $display("FAIL full_addr: got %h want 508", addrRAS_CP_o); else checks_passed++;
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 0, 0, 0, 0, 0, 0);
         checks_total++;
         if (addrRAS_CP_o !== want[i])
            $display("FAIL wrap_pop%0d: got %h want %h", i, addrRAS_CP_o, want[i]);
         else checks_passed++;
      end
   endtask

   task automatic test_empty_pop();
      logic [1:0]  tos_before;
      logic [31:0] addr_before;
      // Continues from the drained stack of test_wrap_full (tos=1).
      tos_before  = 2'(m_tos);
      addr_before = m_ent[m_tos];
      cycle(0, 1, 0, 0, 0, 0, 0, 0);
      checks_total++;
      if (tos_o !== tos_before) $display("FAIL empty_pop_tos: got %0d want %0d", tos_o, tos_before); else checks_passed++;
      checks_total++;
      if (count_o !== 3'd0) $display("FAIL empty_pop_count: got %0d want 0", count_o); else checks_passed++;
      checks_total++;
      if (rasEmpty_o !== 1'b1) $display("FAIL empty_pop_flag: got %b want 1", rasEmpty_o); else checks_passed++;
      checks_total++;
      if (addrRAS_CP_o !== addr_before) $display("FAIL empty_pop_addr: got %h want %h", addrRAS_CP_o, addr_before); else checks_passed++;
   endtask

   task automatic test_push_pop();
      do_reset();
      cycle(1, 0, 0, 0, 32'h2000, 0, 0, 0);
      cycle(1, 1, 0, 0, 32'h3000, 0, 0, 0);
      checks_total++;
      if (addrRAS_CP_o !== 32'h3008) $display("FAIL pushpop_addr: got %h want 3008", addrRAS_CP_o); else checks_passed++;
      checks_total++;
      if (count_o !== 3'd1) $display("FAIL pushpop_count: got %0d want 1", count_o); else checks_passed++;
      checks_total++;
      if (tos_o !== 2'd1) $display("FAIL pushpop_tos: got %0d want 1", tos_o); else checks_passed++;
   endtask

   task automatic test_stall();
      logic [1:0] t0;
      logic [2:0] c0;
      t0 = tos_o;
      c0 = count_o;
      cycle(1, 0, 1, 0, 32'h7777, 0, 0, 0);
      cycle(0, 1, 1, 0, 32'h0, 0, 0, 0);
      checks_total++;
      if (tos_o !== t0 || count_o !== c0)
         $display("FAIL stall_hold: got tos %0d count %0d want tos %0d count %0d", tos_o, count_o, t0, c0);
      else checks_passed++;
      checks_total++;
      if (addrRAS_CP_o !== 32'h3008) $display("FAIL stall_addr: got %h want 3008", addrRAS_CP_o); else checks_passed++;
   endtask

   task automatic test_recover();
      do_reset();
      cycle(1, 0, 0, 0, 32'h4000, 0, 0, 0);
      cycle(1, 0, 0, 0, 32'h5000, 0, 0, 0);
      cycle(1, 0, 0, 0, 32'h6000, 0, 0, 0);
      cycle(1, 0, 1, 1, 32'h9000, 2'd2, 3'd2, 32'hABC8);
`ifdef RAS_CHECKPOINT_EN
      checks_total++;
      if (tos_o !== 2'd2) $display("FAIL recover_tos: got %0d want 2", tos_o); else checks_passed++;
      checks_total++;
      if (count_o !== 3'd2) $display("FAIL recover_count: got %0d want 2", count_o); else checks_passed++;
      checks_total++;
      if (addrRAS_CP_o !== 32'hABC8) $display("FAIL recover_addr: got %h want abc8", addrRAS_CP_o); else checks_passed++;
`else
      checks_total++;
      if (tos_o !== 2'd0) $display("FAIL recover_tos: got %0d want 0", tos_o); else checks_passed++;
      checks_total++;
      if (count_o !== 3'd0) $display("FAIL recover_count: got %0d want 0", count_o); else checks_passed++;
      checks_total++;
      if (addrRAS_CP_o !== 32'h0) $display("FAIL recover_addr: got %h want 0", addrRAS_CP_o); else checks_passed++;
`endif
   endtask

   task automatic test_reset_mid_push();
      cycle(1, 0, 0, 0, 32'h1111, 0, 0, 0);
      pushFlag_i = 1'b1;
      callPC_i   = 32'h2222;
      #2 reset = 1'b0;
      #1;
      checks_total++;
      if (addrRAS_CP_o !== 32'h0 || tos_o !== 2'd0 || count_o !== 3'd0 || rasEmpty_o !== 1'b1 || rasFull_o !== 1'b0)
         $display("FAIL reset_mid_async: got addr %h tos %0d count %0d empty %b full %b want 0 0 0 1 0",
                  addrRAS_CP_o, tos_o, count_o, rasEmpty_o, rasFull_o);
      else checks_passed++;
      model_reset();
      @(negedge clk);
      pushFlag_i = 1'b0;
      reset      = 1'b1;
      checks_total++;
      if (count_o !== 3'd0 || tos_o !== 2'd0) $display("FAIL reset_mid_lost: got tos %0d count %0d want 0 0", tos_o, count_o); else checks_passed++;
      cycle(1, 0, 0, 0, 32'h3330, 0, 0, 0);
      checks_total++;
      if (addrRAS_CP_o !== 32'h3338 || count_o !== 3'd1) $display("FAIL reset_mid_first: got addr %h count %0d want 3338 1", addrRAS_CP_o, count_o); else checks_passed++;
   endtask

   task automatic test_random();
      logic        push, pop, stall, rec;
      logic [31:0] pc, top;
      logic [1:0]  ct;
      logic [2:0]  cc;
      for (int n = 0; n < 400; n++) begin
         push  = ($urandom_range(0, 99) < 55);
         pop   = ($urandom_range(0, 99) < 45);
         stall = ($urandom_range(0, 99) < 15);
         rec   = ($urandom_range(0, 99) < 5);
         pc    = (n % 50 == 7) ? 32'hFFFF_FFFC : $urandom;
         top   = $urandom;
         ct    = 2'($urandom_range(0, DEPTH - 1));
         cc    = 3'($urandom_range(0, DEPTH));
         cycle(push, pop, stall, rec, pc, ct, cc, top);
         checks_total++;
         if (addrRAS_CP_o !== m_ent[m_tos] || tos_o !== 2'(m_tos) || count_o !== 3'(m_count)
             || rasEmpty_o !== (m_count == 0) || rasFull_o !== (m_count == DEPTH))
            $display("FAIL random_%0d: got addr %h tos %0d count %0d empty %b full %b want addr %h tos %0d count %0d",
                     n, addrRAS_CP_o, tos_o, count_o, rasEmpty_o, rasFull_o, m_ent[m_tos], m_tos, m_count);
         else checks_passed++;
      end
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      reset         = 1'b0;
      stall_i       = 1'b0;
      pushFlag_i    = 1'b0;
      popFlag_i     = 1'b0;
      recoverFlag_i = 1'b0;
      callPC_i      = '0;
      cpTos_i       = '0;
      cpCount_i     = '0;
      cpTopAddr_i   = '0;
      @(negedge clk);
      test_reset();
      test_single_push();
      test_wrap_full();
      test_empty_pop();
      test_push_pop();
      test_stall();
      test_recover();
      test_reset_mid_push();
      do_reset();
      test_random();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
